dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port 256x16 data memory between the processor controller and a host/debug port (program/data loader, test harness). The CPU always has priority. The host is served in free cycles, or by freezing the CPU through cpu_hold once a starvation limit is hit. The block sits between the controller/register-file outputs (D_Addr, D_Wr, A-side data) and the data RAM.

Parameters:
AW, 8, address width.
DW, 16, data width.
STARVE_LIMIT, 8, consecutive busy-CPU cycles a pending host request waits before the CPU is frozen (1..255).

Ports:
Clock  in  1  system clock; all state updates on rising edge.
Reset  in  1  synchronous, active-low.
cpu_addr  in  AW  CPU data address.
cpu_wr  in  1  CPU write enable.
cpu_rd  in  1  CPU read in progress (load states).
cpu_wdata  in  DW  CPU write data (register file A-side).
host_req  in  1  host access request; held high until host_gnt.
host_we  in  1  host write (1) / read (0).
host_addr  in  AW  host address.
host_wdata  in  DW  host write data.
host_gnt  out  1  one-cycle pulse: host access performed this cycle.
host_rdata  out  DW  registered host read data.
host_rvalid  out  1  one-cycle pulse: host_rdata valid.
cpu_hold  out  1  freeze request to controller/PC/IR/RF write enables.
owner  out  1  0 = CPU drives memory, 1 = host.
mem_addr  out  AW  to RAM.
mem_wr  out  1  to RAM.
mem_wdata  out  DW  to RAM.
mem_rdata  in  DW  from RAM; valid the cycle after the address (1-cycle read latency).

Behaviour:
- Reset (Reset=0 at edge): state IDLE, wait counter 0, latched request cleared. host_gnt=0, host_rvalid=0, host_rdata=0, cpu_hold=0, owner=0. In-flight host access is discarded; no rvalid follows.
- owner=0: mem_addr/mem_wr/mem_wdata = cpu_* combinationally.
- owner=1: mem_* = latched host request. mem_wr = latched host_we only in ACCESS, else 0.
- cpu_busy = cpu_rd | cpu_wr.
- IDLE:
  - host_req=1 latches host_we/addr/wdata and clears the counter.
  - Goes to ACCESS if cpu_busy=0, else to WAIT.
  - CPU wins any simultaneous start.
- WAIT:
  - host_req=0 aborts to IDLE; no gnt.
  - Else if cpu_busy=0, go to ACCESS.
  - Else the counter increments, saturating. When counter = STARVE_LIMIT-1 while busy, go to HOLD.
- HOLD: cpu_hold=1, owner=0, exactly 1 cycle, then ACCESS. This lets the controller freeze cleanly at the edge.
- ACCESS: owner=1, host_gnt=1 (Moore). Read goes to RESP; write goes to IDLE (the RAM write commits at this edge).
- RESP: owner=1. At the end of the cycle host_rdata <= mem_rdata and host_rvalid=1 in the following cycle; then go to IDLE.
- Read latency: gnt at cycle t, rvalid/rdata at t+2. Write: gnt at t, data in RAM after edge t.
- cpu_hold stays 1 from HOLD through ACCESS and RESP (or ACCESS only for writes) when entered via HOLD; otherwise it stays 0.
- A held CPU resumes with its own access re-presented. A frozen load re-reads memory after release.
- Back-to-back: host_req still high in IDLE after a completed access starts a new request. Minimum 2 cycles per write and 3 cycles per read.
- host_we/addr/wdata changes after latching are ignored until the next IDLE.
- Counter width is $clog2(STARVE_LIMIT+1).
- STARVE_LIMIT=1: a busy CPU goes straight from IDLE to HOLD.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, WAIT, HOLD, ACCESS, RESP};
  - OWNER_CPU=0 and OWNER_HOST=1;
  - default AW/DW.
- One sub-module, starve_timer: saturating counter with clear/enable and a limit-reached flag.

Test Plan:
- Idle CPU: host write addr 8'h1A data 16'hBEEF → gnt at cycle 1, mem_wr=1, mem_addr=1A; then host read 1A → rvalid 2 cycles after gnt with rdata=BEEF.
- CPU busy (cpu_rd=1) for 3 cycles with a host read pending, STARVE_LIMIT=8 → no cpu_hold; gnt the first cycle cpu_busy=0.
- CPU busy continuously, STARVE_LIMIT=4 → cpu_hold rises after 4 wait cycles, gnt 1 cycle later, cpu_hold drops after RESP; CPU address restored on mem_addr.
- host_req and cpu_wr rise in the same cycle → CPU write to 8'h20 completes first; host gnt follows when cpu_wr drops.
- host_req dropped in WAIT → no gnt, no rvalid, state returns to IDLE, counter 0.
- Reset=0 during RESP → next cycle all outputs at reset values; no rvalid pulse ever appears.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU and the host/debug port.
package dmem_arb_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 16;

  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HOLD,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_arbiter_starve_timer.sv
// Saturating count of busy-CPU cycles a pending host request has waited, with a limit-reached flag.
module starve_timer #(
  parameter int unsigned LIMIT = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic limit_hit_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (!Reset || clr) begin
      count <= '0;
    end else if (en && (count != CW'(LIMIT))) begin
      count <= count + CW'(1);
    end
  end

  // Flags the last busy cycle the host may wait before the CPU is frozen.
  assign limit_hit_c = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU (priority) and the host port,
// freezing the CPU through cpu_hold when a host request has starved too long.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_wr,
  input  logic          cpu_rd,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          cpu_hold,
  output logic          owner,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic cpu_busy_c;
  logic timer_clr_c;
  logic timer_en_c;
  logic limit_hit_c;

  assign cpu_busy_c  = cpu_rd | cpu_wr;
  assign timer_clr_c = (state != WAIT) || !host_req;
  assign timer_en_c  = (state == WAIT) && cpu_busy_c;

  starve_timer #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_timer (
    .Clock       (Clock),
    .Reset       (Reset),
    .clr         (timer_clr_c),
    .en          (timer_en_c),
    .limit_hit_c (limit_hit_c)
  );

  // The counter is always zero in IDLE, so limit_hit_c there means a limit of one cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      host_gnt    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      cpu_hold    <= 1'b0;
      owner       <= OWNER_CPU;
    end else begin
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (host_req) begin
            lat_we    <= host_we;
            lat_addr  <= host_addr;
            lat_wdata <= host_wdata;
            if (!cpu_busy_c) begin
              state    <= ACCESS;
              host_gnt <= 1'b1;
              owner    <= OWNER_HOST;
            end else if (limit_hit_c) begin
              state    <= HOLD;
              cpu_hold <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!host_req) begin
            state <= IDLE;
          end else if (!cpu_busy_c) begin
            state    <= ACCESS;
            host_gnt <= 1'b1;
            owner    <= OWNER_HOST;
          end else if (limit_hit_c) begin
            state    <= HOLD;
            cpu_hold <= 1'b1;
          end
        end
        HOLD: begin
          state    <= ACCESS;
          host_gnt <= 1'b1;
          owner    <= OWNER_HOST;
        end
        ACCESS: begin
          if (lat_we) begin
            state    <= IDLE;
            owner    <= OWNER_CPU;
            cpu_hold <= 1'b0;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          state       <= IDLE;
          host_rdata  <= mem_rdata;
          host_rvalid <= 1'b1;
          owner       <= OWNER_CPU;
          cpu_hold    <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          owner    <= OWNER_CPU;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux; a host write strobes only during the granted cycle.
  assign mem_addr  = (owner == OWNER_HOST) ? lat_addr : cpu_addr;
  assign mem_wdata = (owner == OWNER_HOST) ? lat_wdata : cpu_wdata;
  assign mem_wr    = (owner == OWNER_HOST) ? ((state == ACCESS) && lat_we) : cpu_wr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized host/CPU traffic
// checked against a transaction-level timing model and a reference memory.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned LIMIT = 4;
  // Consecutive busy cycles (counting the request cycle) that force a freeze.
  localparam int H = (LIMIT == 1) ? 1 : int'(LIMIT) + 1;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [AW-1:0] cpu_addr;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [DW-1:0] cpu_wdata;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          cpu_hold;
  logic          owner;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] ref_mem [256];

  always #5 Clock = ~Clock;

  dmem_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .cpu_addr    (cpu_addr),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .cpu_wdata   (cpu_wdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .cpu_hold    (cpu_hold),
    .owner       (owner),
    .mem_addr    (mem_addr),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Single-port RAM with one-cycle read latency.
  logic [DW-1:0] ram [256] = '{default: '0};
  logic [DW-1:0] ram_q;
  always @(posedge Clock) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_q;

  task automatic cpu_idle();
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    cpu_addr = AW'($urandom);
    cpu_wdata = DW'($urandom);
  endtask

  // One host transaction; the CPU is busy for busy_len cycles from the request cycle
  // (or, when frozen, until one cycle after release).
  task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int busy_len, input logic cwe, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd);
    bit hold;
    bit saw_gnt;
    int g;
    int last_own;
    int e;
    logic exp_own;
    logic [DW-1:0] exp_rd;
    logic [28:0] exp_v;
    logic [28:0] act_v;
    hold = (busy_len >= H);
    g = hold ? H + 1 : busy_len + 1;
    last_own = we ? g : g + 1;
    e = last_own + 1;
    saw_gnt = 1'b0;
    exp_rd = '0;
    for (int c = 0; c <= e; c++) begin
      @(posedge Clock); #1;
      if (c == 0) begin
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
      end else if (saw_gnt) begin
        host_req = 1'b0;
      end else begin
        host_we = ~host_we; host_addr = AW'($urandom); host_wdata = DW'($urandom);
      end
      if (hold || (c < busy_len)) begin
        cpu_wr = cwe; cpu_rd = ~cwe; cpu_addr = ca; cpu_wdata = cd;
      end else begin
        cpu_idle();
      end
      @(negedge Clock);
      exp_own = (c >= g) && (c <= last_own);
      exp_v = {c == g, exp_own, hold && (c >= H) && (c <= last_own), !we && (c == g + 2),
               exp_own ? (we && (c == g)) : cpu_wr,
               exp_own ? a : cpu_addr,
               exp_own ? d : cpu_wdata};
      act_v = {host_gnt, owner, cpu_hold, host_rvalid, mem_wr, mem_addr, mem_wdata};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL txn_cycle%0d gnt/own/hold/rvalid/wr/addr/wdata got %h expected %h", c, act_v, exp_v);
      end
      if (!we && (c == g + 2)) begin
        total++;
        if (host_rdata !== exp_rd) begin
          bad++;
          $display("FAIL txn_rdata addr %h got %h expected %h", a, host_rdata, exp_rd);
        end
      end
      if (host_gnt) saw_gnt = 1'b1;
      if (!exp_own && cpu_wr) ref_mem[cpu_addr] = cpu_wdata;
      if (c == g) begin
        if (we) ref_mem[a] = d;
        else exp_rd = ref_mem[a];
      end
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 8'h5C; cpu_wdata = 16'h1357;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    total++;
    if ({host_gnt, host_rvalid, cpu_hold, owner, host_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got gnt=%b rv=%b hold=%b own=%b rdata=%h expected all zero",
               host_gnt, host_rvalid, cpu_hold, owner, host_rdata);
    end
    total++;
    if ({mem_addr, mem_wr, mem_wdata} !== {8'h5C, 1'b1, 16'h1357}) begin
      bad++;
      $display("FAIL reset_cpu_path got %h/%b/%h expected 5c/1/1357", mem_addr, mem_wr, mem_wdata);
    end
    @(posedge Clock); #1;
    Reset = 1'b1;
    ref_mem[8'h5C] = 16'h1357;
    cpu_idle();
  endtask

  task automatic test_idle_write_read();
    run_txn(1'b1, 8'h1A, 16'hBEEF, 0, 1'b0, 8'h00, 16'h0000);
    run_txn(1'b0, 8'h1A, 16'h0000, 0, 1'b0, 8'h00, 16'h0000);
    total++;
    if (host_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL idle_readback got %h expected beef", host_rdata);
    end
  endtask

  task automatic test_busy_short();
    run_txn(1'b0, 8'h1A, 16'h0000, 3, 1'b0, 8'h77, 16'h0000);
  endtask

  task automatic test_starve();
    run_txn(1'b0, 8'h1A, 16'h0000, 12, 1'b0, 8'h66, 16'h0000);
    run_txn(1'b1, 8'h22, 16'hC0DE, 12, 1'b1, 8'h23, 16'h1111);
  endtask

  task automatic test_simultaneous();
    run_txn(1'b0, 8'h20, 16'h0000, 1, 1'b1, 8'h20, 16'h1234);
    total++;
    if (host_rdata !== 16'h1234) begin
      bad++;
      $display("FAIL simultaneous_cpu_first got %h expected 1234", host_rdata);
    end
  endtask

  task automatic test_abort();
    logic [4:0] act;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clock); #1;
      host_req = (c < 3); host_we = 1'b1; host_addr = 8'h33; host_wdata = 16'hDEAD;
      if (c < 5) begin
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h10; cpu_wdata = 16'h0000;
      end else begin
        cpu_idle();
      end
      @(negedge Clock);
      act = {host_gnt, owner, cpu_hold, host_rvalid, mem_wr};
      total++;
      if (act !== 5'b00000) begin
        bad++;
        $display("FAIL abort_cycle%0d gnt/own/hold/rv/wr got %b expected 00000", c, act);
      end
    end
    run_txn(1'b0, 8'h33, 16'h0000, H - 1, 1'b0, 8'h10, 16'h0000);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tab [9];
    logic [3:0] act;
    exp_tab = '{4'b0000, 4'b1101, 4'b0000, 4'b1101, 4'b0000, 4'b1100, 4'b0100, 4'b0010, 4'b0000};
    cpu_idle();
    for (int c = 0; c < 9; c++) begin
      @(posedge Clock); #1;
      case (c)
        0: begin host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 16'hA5A5; end
        2: begin host_we = 1'b1; host_addr = 8'h41; host_wdata = 16'h5A5A; end
        4: begin host_we = 1'b0; host_addr = 8'h40; host_wdata = 16'h0000; end
        6: host_req = 1'b0;
        default: ;
      endcase
      @(negedge Clock);
      act = {host_gnt, owner, host_rvalid, mem_wr};
      total++;
      if (act !== exp_tab[c]) begin
        bad++;
        $display("FAIL b2b_cycle%0d gnt/own/rv/wr got %b expected %b", c, act, exp_tab[c]);
      end
      if (c == 7) begin
        total++;
        if (host_rdata !== 16'hA5A5) begin
          bad++;
          $display("FAIL b2b_rdata got %h expected a5a5", host_rdata);
        end
      end
    end
    ref_mem[8'h40] = 16'hA5A5;
    ref_mem[8'h41] = 16'h5A5A;
  endtask

  task automatic test_reset_in_resp();
    logic [2:0] exp_tab [6];
    logic [2:0] act;
    exp_tab = '{3'b000, 3'b110, 3'b010, 3'b000, 3'b000, 3'b000};
    cpu_idle();
    for (int c = 0; c < 6; c++) begin
      @(posedge Clock); #1;
      host_req = (c < 2); host_we = 1'b0; host_addr = 8'h1A;
      Reset = (c != 2);
      @(negedge Clock);
      act = {host_gnt, owner, host_rvalid};
      total++;
      if (act !== exp_tab[c]) begin
        bad++;
        $display("FAIL rst_resp_cycle%0d gnt/own/rv got %b expected %b", c, act, exp_tab[c]);
      end
      if (c == 3) begin
        total++;
        if ({cpu_hold, host_rdata} !== '0) begin
          bad++;
          $display("FAIL rst_resp_clear got hold=%b rdata=%h expected 0/0000", cpu_hold, host_rdata);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
              int'($urandom_range(0, H + 2)), 1'($urandom),
              AW'($urandom_range(0, 15)), DW'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    test_reset();
    test_idle_write_read();
    test_busy_short();
    test_starve();
    test_simultaneous();
    test_abort();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
